// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared types and default address-map constants for io_bridge.
//   rd_sel_e   - source selected for core_read_value in the cycle after acceptance
//   state_e    - I/O handshake FSM states
//   WINDOW_BASE / STATUS_ADDR - lowest I/O window address and status register
//                               address for the default 16-bit / 7-bit geometry
package io_bridge_pkg;

  localparam int ADDR_WIDTH_DEF  = 16;
  localparam int WINDOW_BITS_DEF = 7;

  // Window = every address whose bits above WINDOW_BITS are all ones.
  localparam logic [ADDR_WIDTH_DEF-1:0] WINDOW_BASE =
    {ADDR_WIDTH_DEF{1'b1}} << WINDOW_BITS_DEF;
  localparam logic [ADDR_WIDTH_DEF-1:0] STATUS_ADDR = {ADDR_WIDTH_DEF{1'b1}};

  typedef enum logic [1:0] {
    RD_MEM    = 2'd0,
    RD_IO     = 2'd1,
    RD_STATUS = 2'd2,
    RD_ZERO   = 2'd3
  } rd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/io_bridge_timeout_counter.sv
// io_timeout_counter: cycle counter that flags expiry on its last allowed cycle.
//   clk, reset - clock and synchronous active-high reset
//   clear      - return the count to zero
//   enable     - count this cycle
//   expire     - high while enabled and the count equals TIMEOUT_CYCLES-1
// TIMEOUT_CYCLES = 0 means the counter never expires.
module io_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_r;

  // Count enabled cycles; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_never
      assign expire = 1'b0;
    end else begin : g_expire
      assign expire = enable && (count_r == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/io_bridge.sv
// io_bridge: routes core data-port accesses either to RAM or to memory-mapped
// peripheral channels with a req/ack handshake, bus timeout and sticky status.
//   clk, reset        - clock and synchronous active-high reset
//   core_*            - core data port; core_stall holds the core during I/O
//   mem_*             - RAM port (1-cycle read latency), pass-through address/data
//   io_req/io_ack     - one-hot per-channel handshake
//   io_write/io_index/io_write_value - registered request attributes
//   io_read_value     - flat per-channel read buses, channel c at [c*REG_WIDTH +: REG_WIDTH]
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = 19,
  parameter int REG_WIDTH      = 16,
  parameter int WINDOW_BITS    = WINDOW_BITS_DEF,
  parameter int CH_IDX_BITS    = 5,
  parameter int NUM_CHANNELS   = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          core_addr,
  input  logic [DATA_WIDTH-1:0]          core_write_value,
  input  logic                           core_write_en,
  output logic [DATA_WIDTH-1:0]          core_read_value,
  output logic                           core_stall,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_write_value,
  output logic                           mem_write_en,
  input  logic [DATA_WIDTH-1:0]          mem_read_value,
  output logic [NUM_CHANNELS-1:0]        io_req,
  output logic                           io_write,
  output logic [CH_IDX_BITS-1:0]         io_index,
  output logic [REG_WIDTH-1:0]           io_write_value,
  input  logic [NUM_CHANNELS-1:0]        io_ack,
  input  logic [NUM_CHANNELS*REG_WIDTH-1:0] io_read_value
);

  localparam int CHW = WINDOW_BITS - CH_IDX_BITS;

  // Address decode
  logic                    win_hit_s;
  logic                    status_hit_s;
  logic [CHW-1:0]          ch_s;
  logic                    populated_s;

  // FSM and datapath
  state_e                  state_r, state_n;
  rd_sel_e                 rd_sel_r, rd_sel_n;
  logic                    load_s;
  logic [CHW-1:0]          ch_r;
  logic [CHW-1:0]          ch_next_s;
  logic [NUM_CHANNELS-1:0] io_req_r, io_req_n;
  logic                    io_write_r;
  logic [CH_IDX_BITS-1:0]  io_index_r;
  logic [REG_WIDTH-1:0]    io_write_value_r;
  logic [REG_WIDTH-1:0]    cap_r;
  logic                    err_r;
  logic [CHW-1:0]          err_ch_r;
  logic                    ack_sel_s;
  logic [REG_WIDTH-1:0]    rd_slice_s;
  logic                    expire_s;
  logic                    timeout_s;
  logic                    status_wr_s;
  logic                    in_wait_s;

  assign win_hit_s    = &core_addr[ADDR_WIDTH-1:WINDOW_BITS];
  assign status_hit_s = &core_addr;
  assign ch_s         = core_addr[WINDOW_BITS-1:CH_IDX_BITS];
  assign populated_s  = (32'(ch_s) < 32'(NUM_CHANNELS));

  assign mem_addr        = core_addr;
  assign mem_write_value = core_write_value;
  assign mem_write_en    = core_write_en & ~win_hit_s;

  assign io_req         = io_req_r;
  assign io_write       = io_write_r;
  assign io_index       = io_index_r;
  assign io_write_value = io_write_value_r;

  assign in_wait_s = (state_r == ST_WAIT);

  io_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (~in_wait_s),
    .enable (in_wait_s),
    .expire (expire_s)
  );

  // Select the acknowledge and read bus of the channel being served.
  always_comb begin
    ack_sel_s  = 1'b0;
    rd_slice_s = {REG_WIDTH{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ack_sel_s  = ack_sel_s | (io_ack[c] & (ch_r == CHW'(c)));
      rd_slice_s = rd_slice_s |
                   ({REG_WIDTH{ch_r == CHW'(c)}} & io_read_value[c*REG_WIDTH +: REG_WIDTH]);
    end
  end

  // Ack beats an expiry landing on the same cycle.
  assign timeout_s   = in_wait_s && !ack_sel_s && expire_s;
  // Status is only decoded from IDLE; the address held through DONE is not re-decoded.
  assign status_wr_s = (state_r == ST_IDLE) && status_hit_s && core_write_en;

  // Next-state, stall and read-source selection.
  always_comb begin
    state_n    = state_r;
    rd_sel_n   = rd_sel_r;
    core_stall = 1'b0;
    load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_hit_s && !status_hit_s && populated_s) begin
          core_stall = 1'b1;
          load_s     = 1'b1;
          state_n    = ST_WAIT;
        end else if (!win_hit_s) begin
          rd_sel_n = RD_MEM;
        end else if (status_hit_s) begin
          rd_sel_n = RD_STATUS;
        end else begin
          rd_sel_n = RD_ZERO;
        end
      end
      ST_WAIT: begin
        core_stall = 1'b1;
        if (ack_sel_s || expire_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_DONE: begin
        rd_sel_n = RD_IO;
        state_n  = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Request lines for the coming cycle, so io_req comes straight from a flop.
  always_comb begin
    ch_next_s = load_s ? ch_s : ch_r;
    io_req_n  = {NUM_CHANNELS{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      io_req_n[c] = (state_n == ST_WAIT) && (ch_next_s == CHW'(c));
    end
  end

  // FSM state, request attributes and read-source register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      rd_sel_r         <= RD_MEM;
      ch_r             <= {CHW{1'b0}};
      io_req_r         <= {NUM_CHANNELS{1'b0}};
      io_write_r       <= 1'b0;
      io_index_r       <= {CH_IDX_BITS{1'b0}};
      io_write_value_r <= {REG_WIDTH{1'b0}};
    end else begin
      state_r  <= state_n;
      rd_sel_r <= rd_sel_n;
      io_req_r <= io_req_n;
      if (load_s) begin
        ch_r             <= ch_s;
        io_write_r       <= core_write_en;
        io_index_r       <= core_addr[CH_IDX_BITS-1:0];
        io_write_value_r <= core_write_value[REG_WIDTH-1:0];
      end else begin
        ch_r             <= ch_r;
        io_write_r       <= io_write_r;
        io_index_r       <= io_index_r;
        io_write_value_r <= io_write_value_r;
      end
    end
  end

  // Capture peripheral read data, or all ones when the channel timed out.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_r <= {REG_WIDTH{1'b0}};
    end else if (in_wait_s && ack_sel_s) begin
      cap_r <= rd_slice_s;
    end else if (timeout_s) begin
      cap_r <= {REG_WIDTH{1'b1}};
    end else begin
      cap_r <= cap_r;
    end
  end

  // Sticky error flag: a new timeout outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r    <= 1'b0;
      err_ch_r <= {CHW{1'b0}};
    end else if (timeout_s) begin
      err_r    <= 1'b1;
      err_ch_r <= ch_r;
    end else if (status_wr_s) begin
      err_r    <= 1'b0;
      err_ch_r <= {CHW{1'b0}};
    end else begin
      err_r    <= err_r;
      err_ch_r <= err_ch_r;
    end
  end

  // Read data mux driven by the source chosen at acceptance.
  always_comb begin
    case (rd_sel_r)
      RD_MEM:    core_read_value = mem_read_value;
      RD_IO:     core_read_value = DATA_WIDTH'(cap_r);
      RD_STATUS: core_read_value = DATA_WIDTH'({err_ch_r, err_r});
      RD_ZERO:   core_read_value = {DATA_WIDTH{1'b0}};
      default:   core_read_value = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;
  import io_bridge_pkg::*;

  localparam int AW = 16;
  localparam int DW = 19;
  localparam int RW = 16;
  localparam int IB = 5;
  localparam int NC = 3;
  localparam int TO = 64;

  logic           clk;
  logic           reset;
  logic [AW-1:0]  core_addr;
  logic [DW-1:0]  core_write_value;
  logic           core_write_en;
  logic [DW-1:0]  core_read_value;
  logic           core_stall;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_write_value;
  logic           mem_write_en;
  logic [DW-1:0]  mem_read_value;
  logic [NC-1:0]  io_req;
  logic           io_write;
  logic [IB-1:0]  io_index;
  logic [RW-1:0]  io_write_value;
  logic [NC-1:0]  io_ack;
  logic [NC*RW-1:0] io_read_value;

  io_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_WIDTH(RW), .WINDOW_BITS(7),
    .CH_IDX_BITS(IB), .NUM_CHANNELS(NC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .core_addr(core_addr), .core_write_value(core_write_value),
    .core_write_en(core_write_en), .core_read_value(core_read_value),
    .core_stall(core_stall),
    .mem_addr(mem_addr), .mem_write_value(mem_write_value),
    .mem_write_en(mem_write_en), .mem_read_value(mem_read_value),
    .io_req(io_req), .io_write(io_write), .io_index(io_index),
    .io_write_value(io_write_value), .io_ack(io_ack), .io_read_value(io_read_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM environment with 1-cycle read latency.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_write_en) ram[mem_addr] <= mem_write_value;
    mem_read_value <= ram[mem_addr];
  end

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_ram [int];
  logic       exp_err = 1'b0;
  logic [1:0] exp_err_ch = 2'd0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One non-stalling access; rd checked the following cycle when chk_rd.
  task automatic plain_access(input logic [AW-1:0] addr, input logic we,
                              input logic [DW-1:0] wd, input logic chk_rd,
                              input logic [DW-1:0] exp_rd, input string name);
    logic exp_mwe;
    exp_mwe = we && (addr < WINDOW_BASE);
    next_cycle();
    core_addr = addr; core_write_en = we; core_write_value = wd; io_ack = '0;
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b0) begin
      errors++; $display("FAIL %s_stall: got %b expected 0", name, core_stall);
    end
    checks++;
    if (mem_write_en !== exp_mwe) begin
      errors++; $display("FAIL %s_mwe: got %b expected %b", name, mem_write_en, exp_mwe);
    end
    checks++;
    if (io_req !== '0) begin
      errors++; $display("FAIL %s_req: got %b expected 000", name, io_req);
    end
    next_cycle();
    core_write_en = 1'b0;
    @(negedge clk);
    if (chk_rd) begin
      checks++;
      if (core_read_value !== exp_rd) begin
        errors++; $display("FAIL %s_rd: got %h expected %h", name, core_read_value, exp_rd);
      end
    end
  endtask

  // Window access to a populated channel; ack in WAIT cycle k (0 = never),
  // 'other' acks on wrong channels during WAIT cycles before k.
  task automatic io_access(input logic [AW-1:0] addr, input logic we,
                           input logic [DW-1:0] wd, input int k,
                           input logic [NC-1:0] other, input logic [RW-1:0] ack_data,
                           input string name);
    int ch, wc, stall_cnt, exp_stall;
    logic timed, done;
    logic [NC*RW-1:0] bus;
    logic [DW-1:0] exp_rd;
    ch = int'(addr[6:5]);
    timed = !(k != 0 && k <= TO);
    exp_stall = timed ? 1 + TO : 1 + k;
    exp_rd = timed ? DW'(16'hFFFF) : DW'(ack_data);
    bus = (NC*RW)'({$urandom, $urandom});
    bus[ch*RW +: RW] = ack_data;
    next_cycle();
    core_addr = addr; core_write_en = we; core_write_value = wd;
    io_ack = '0; io_read_value = bus;
    stall_cnt = 0; wc = 0; done = 1'b0;
    for (int cyc = 0; cyc < TO + 20 && !done; cyc++) begin
      @(negedge clk);
      checks++;
      if (mem_write_en !== 1'b0) begin
        errors++; $display("FAIL %s_mwe: got %b expected 0", name, mem_write_en);
      end
      if (!core_stall) begin
        done = 1'b1;
      end else begin
        stall_cnt++;
        if (wc > 0) begin
          checks++;
          if (io_req !== NC'(1 << ch) || io_index !== addr[IB-1:0] ||
              io_write !== we || io_write_value !== wd[RW-1:0]) begin
            errors++;
            $display("FAIL %s_req: got req=%b idx=%0d wr=%b wv=%h expected req=%b idx=%0d wr=%b wv=%h",
                     name, io_req, io_index, io_write, io_write_value,
                     NC'(1 << ch), addr[IB-1:0], we, wd[RW-1:0]);
          end
        end
        next_cycle();
        wc++;
        io_ack = (wc == k) ? NC'(1 << ch) : ((wc < k) ? other : '0);
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s_bound: stall never released, expected release after %0d", name, exp_stall);
    end
    checks++;
    if (stall_cnt != exp_stall) begin
      errors++; $display("FAIL %s_stallcnt: got %0d expected %0d", name, stall_cnt, exp_stall);
    end
    checks++;
    if (io_req !== '0) begin
      errors++; $display("FAIL %s_done_req: got %b expected 000", name, io_req);
    end
    next_cycle();
    core_addr = 16'h0000; core_write_en = 1'b0; io_ack = '0;
    @(negedge clk);
    if (!we) begin
      checks++;
      if (core_read_value !== exp_rd) begin
        errors++; $display("FAIL %s_rd: got %h expected %h", name, core_read_value, exp_rd);
      end
    end
    if (timed) begin
      exp_err = 1'b1; exp_err_ch = 2'(ch);
    end
  endtask

  task automatic check_status(input string name);
    plain_access(STATUS_ADDR, 1'b0, '0, 1'b1, DW'({exp_err_ch, exp_err}), name);
  endtask

  task automatic test_reset();
    reset = 1'b1; core_addr = '0; core_write_en = 1'b0; core_write_value = '0;
    io_ack = '0; io_read_value = '0;
    repeat (3) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (io_req !== '0 || core_stall !== 1'b0 || io_write !== 1'b0 ||
        io_index !== '0 || io_write_value !== '0 || mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b stall=%b wr=%b idx=%0d wv=%h mwe=%b expected all 0",
               io_req, core_stall, io_write, io_index, io_write_value, mem_write_en);
    end
    exp_err = 1'b0; exp_err_ch = 2'd0;
    check_status("reset_status");
  endtask

  task automatic test_ram();
    logic [AW-1:0] a [6];
    logic [DW-1:0] d;
    plain_access(16'h0100, 1'b1, 19'h01234, 1'b0, '0, "ram_wr0100");
    exp_ram[16'h0100] = 19'h01234;
    plain_access(16'h0100, 1'b0, '0, 1'b1, 19'h01234, "ram_rd0100");
    for (int i = 0; i < 6; i++) begin
      a[i] = AW'($urandom_range(0, 16'hFF7F));
      d = DW'($urandom);
      plain_access(a[i], 1'b1, d, 1'b0, '0, "ram_wr");
      exp_ram[int'(a[i])] = d;
    end
    for (int i = 0; i < 6; i++) begin
      plain_access(a[i], 1'b0, '0, 1'b1, exp_ram[int'(a[i])], "ram_rd");
    end
  endtask

  task automatic test_io_basic();
    io_access(16'hFFA3, 1'b0, 19'h00000, 3, 3'b000, 16'hBEEF, "io_rd_ch1");
    io_access(16'hFF85, 1'b1, 19'h05A5A, 4, 3'b100, 16'h1111, "io_wr_wrongack");
    io_access(16'hFFC7, 1'b0, 19'h00000, 1, 3'b000, 16'h0042, "io_min");
  endtask

  task automatic test_io_random();
    int ch, k;
    logic [NC-1:0] other;
    for (int i = 0; i < 8; i++) begin
      ch = $urandom_range(0, NC - 1);
      k = $urandom_range(1, 6);
      other = NC'($urandom) & ~NC'(1 << ch);
      io_access(16'hFF80 | AW'(ch << 5) | AW'($urandom_range(0, 31)),
                1'($urandom), DW'($urandom), k, other, RW'($urandom), "io_rand");
    end
  endtask

  task automatic test_timeout();
    io_access(16'hFFC4, 1'b0, '0, 0, 3'b000, 16'h7777, "io_timeout");
    check_status("status_after_timeout");
    plain_access(STATUS_ADDR, 1'b1, DW'($urandom), 1'b0, '0, "status_clear");
    exp_err = 1'b0; exp_err_ch = 2'd0;
    check_status("status_cleared");
  endtask

  task automatic test_boundary();
    plain_access(16'hFFE0 | AW'($urandom_range(0, 30)), 1'b0, '0, 1'b1, '0, "unpop_rd");
    plain_access(16'hFFE3, 1'b1, DW'(19'h7FFFF), 1'b1, '0, "unpop_wr");
    io_access(16'hFFA9, 1'b0, '0, TO, 3'b000, 16'hCAFE, "ack_at_timeout");
    check_status("status_ack_at_timeout");
  endtask

  task automatic test_reset_mid_wait();
    next_cycle();
    core_addr = 16'hFFAC; core_write_en = 1'b0; io_ack = '0;
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b1) begin
      errors++; $display("FAIL rst_wait_stall: got %b expected 1", core_stall);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1; core_addr = 16'h0100;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (io_req !== '0 || core_stall !== 1'b0) begin
      errors++; $display("FAIL rst_wait_abort: got req=%b stall=%b expected 000/0", io_req, core_stall);
    end
    exp_err = 1'b0; exp_err_ch = 2'd0;
    check_status("rst_wait_status");
    plain_access(16'h0100, 1'b0, '0, 1'b1, exp_ram[16'h0100], "rst_wait_ram");
    io_access(16'hFF81, 1'b0, '0, 2, 3'b000, 16'h0ABC, "rst_wait_next_io");
  endtask

  initial begin
    test_reset();
    test_ram();
    test_io_basic();
    test_io_random();
    test_timeout();
    test_boundary();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
